// File: rtl/jailbreak_hiscore_if.sv
// Bridge bus bundle for the high-score leaf: address/data/strobes from the
// bridge, select and registered read data back from the leaf.
interface jailbreak_hiscore_if;
  logic [31:0] bridge_addr;
  logic [31:0] bridge_wr_data;
  logic        bridge_wr;
  logic        bridge_rd;
  logic        hs_selected;
  logic [31:0] hs_rd_data;

  modport master (
    output bridge_addr,
    output bridge_wr_data,
    output bridge_wr,
    output bridge_rd,
    input  hs_selected,
    input  hs_rd_data
  );

  modport slave (
    input  bridge_addr,
    input  bridge_wr_data,
    input  bridge_wr,
    input  bridge_rd,
    output hs_selected,
    output hs_rd_data
  );
endinterface

// File: rtl/jailbreak_hiscore.sv
// High-score bridge leaf: shadows the game's score table by snooping CPU
// writes, exposes it to the host over the bridge (save/load), and replays a
// loaded table back into game RAM through a ready/valid style write port.
module jailbreak_hiscore #(
  parameter logic [31:0] HS_BASE_ADDR = 32'h00200000,
  parameter int          HS_BYTES     = 64,
  parameter logic [15:0] GAME_BASE    = 16'h8000,
  parameter logic [31:0] STATUS_ADDR  = 32'h00200400
) (
  input  logic                clk_74a,
  input  logic                reset_n,
  jailbreak_hiscore_if.slave  bridge,
  input  logic [15:0]         cpu_addr,
  input  logic                cpu_wr,
  input  logic [7:0]          cpu_wr_data,
  input  logic                restore_start,
  output logic                restore_wr,
  output logic [15:0]         restore_addr,
  output logic [7:0]          restore_data,
  input  logic                restore_ready,
  output logic                restore_busy
);

  localparam int              IDX_W     = $clog2(HS_BYTES);
  localparam logic [IDX_W-1:0] LANE_MASK = ~IDX_W'(3);
  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(HS_BYTES - 4);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(HS_BYTES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]          state_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [IDX_W-1:0]    idx_inc;
  logic                wr_reg;
  logic                busy_reg;
  logic [15:0]         addr_reg;
  logic [7:0]          data_reg;
  logic                dirty_reg;
  logic                loaded_reg;
  logic [31:0]         rd_data_reg;

  // Bridge decode. The subtraction wraps for addresses below the base, so a
  // single unsigned compare covers both window bounds.
  logic [31:0]         win_off;
  logic                win;
  logic                status_hit;
  logic [IDX_W-1:0]    word_base;
  logic                buf_bridge_wr;
  logic                status_wr;

  assign win_off            = bridge.bridge_addr - HS_BASE_ADDR;
  assign win                = (win_off < 32'(HS_BYTES));
  assign status_hit         = (bridge.bridge_addr == STATUS_ADDR);
  assign bridge.hs_selected = win | status_hit;
  assign word_base          = win_off[IDX_W-1:0] & LANE_MASK;
  assign buf_bridge_wr      = bridge.bridge_wr & win & ~busy_reg;
  assign status_wr          = bridge.bridge_wr & status_hit;

  // Snoop decode in 17 bits so a table ending past 16'hFFFF still decodes.
  logic [16:0]         cpu_off;
  logic                snoop_hit;
  logic [IDX_W-1:0]    snoop_idx;

  assign cpu_off   = {1'b0, cpu_addr} - {1'b0, GAME_BASE};
  assign snoop_hit = cpu_wr & ~busy_reg
                   & ({1'b0, cpu_addr} >= {1'b0, GAME_BASE})
                   & (cpu_off < 17'(HS_BYTES));
  assign snoop_idx = cpu_off[IDX_W-1:0];

  // Buffer as individual byte registers: a bridge word write and a snoop byte
  // write can land on different bytes in the same cycle, which a single-port
  // RAM could not absorb. Flattened for indexed reads.
  logic [8*HS_BYTES-1:0] buf_flat;

  genvar gi;
  generate
    for (gi = 0; gi < HS_BYTES; gi++) begin : g_byte
      localparam logic [IDX_W-1:0] WORD_OF = IDX_W'(gi & ~3);
      localparam int               LANE    = gi % 4;
      logic [7:0] byte_reg;
      logic       lane_wr;
      logic       snoop_wr;

      assign lane_wr  = buf_bridge_wr & (word_base == WORD_OF);
      assign snoop_wr = snoop_hit & (snoop_idx == IDX_W'(gi));

      // Byte update; the bridge lane wins over a same-cycle snoop.
      always_ff @(posedge clk_74a) begin
        if (lane_wr)
          byte_reg <= bridge.bridge_wr_data[31-8*LANE -: 8];
        else if (snoop_wr)
          byte_reg <= cpu_wr_data;
      end

      assign buf_flat[8*gi +: 8] = byte_reg;
    end
  endgenerate

  // Big-endian word view of the addressed window word.
  logic [31:0] rd_word;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign rd_word[31-8*gi -: 8] = buf_flat[{(word_base | IDX_W'(gi)), 3'b000} +: 8];
    end
  endgenerate

  // Registered bridge read; unselected reads leave the last value in place.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_reg <= '0;
    end else if (bridge.bridge_rd) begin
      if (win)
        rd_data_reg <= rd_word;
      else if (status_hit)
        rd_data_reg <= {29'b0, loaded_reg, busy_reg, dirty_reg};
    end
  end

  assign bridge.hs_rd_data = rd_data_reg;

  // Loaded flag: set by writing the final window word, cleared via status bit2.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n)
      loaded_reg <= 1'b0;
    else if (status_wr && bridge.bridge_wr_data[2])
      loaded_reg <= 1'b0;
    else if (buf_bridge_wr && (word_base == LAST_WORD))
      loaded_reg <= 1'b1;
  end

  // Dirty flag: a snoop hit beats any clear in the same cycle.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n)
      dirty_reg <= 1'b0;
    else if (snoop_hit)
      dirty_reg <= 1'b1;
    else if ((status_wr && bridge.bridge_wr_data[0]) || (state_reg == ST_DONE))
      dirty_reg <= 1'b0;
  end

  assign idx_inc = idx_reg + 1'b1;

  // Replay sequencer: presents one byte at a time, holding it until accepted.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      wr_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (restore_start && loaded_reg) begin
            state_reg <= ST_WRITE;
            idx_reg   <= '0;
            wr_reg    <= 1'b1;
            busy_reg  <= 1'b1;
            addr_reg  <= GAME_BASE;
            data_reg  <= buf_flat[7:0];
          end
        end
        ST_WRITE: begin
          if (restore_ready) begin
            if (idx_reg == LAST_IDX) begin
              state_reg <= ST_DONE;
              wr_reg    <= 1'b0;
              busy_reg  <= 1'b0;
            end else begin
              idx_reg  <= idx_inc;
              addr_reg <= GAME_BASE + 16'(idx_inc);
              data_reg <= buf_flat[{idx_inc, 3'b000} +: 8];
            end
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
          wr_reg    <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign restore_wr   = wr_reg;
  assign restore_busy = busy_reg;
  assign restore_addr = addr_reg;
  assign restore_data = data_reg;

endmodule
